// File: rtl/nv_nvdla_csb_pkg.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_pkg
// Shared definitions for the CSB initiator toward the GLB register slave:
//   - csb2glb request packet field offsets/widths and a packing helper
//   - glb2csb response packet field offsets and response type codes
//   - constant request fields (source privilege, byte enables, level)
//   - FSM state encoding of the initiator
// No ports (package).
// -----------------------------------------------------------------------------
package nv_nvdla_csb_pkg;

   localparam int ADDR_W    = 22;
   localparam int DATA_W    = 32;
   localparam int WRBE_W    = 4;
   localparam int LEVEL_W   = 2;
   localparam int REQ_PD_W  = 63;
   localparam int RESP_PD_W = 34;

   // csb2glb_req_pd layout
   localparam int PD_ADDR_LSB    = 0;
   localparam int PD_WDAT_LSB    = 22;
   localparam int PD_WRITE_BIT   = 54;
   localparam int PD_NPOSTED_BIT = 55;
   localparam int PD_SRCPRIV_BIT = 56;
   localparam int PD_WRBE_LSB    = 57;
   localparam int PD_LEVEL_LSB   = 61;

   // glb2csb_resp_pd layout
   localparam int RSP_RDAT_LSB  = 0;
   localparam int RSP_ERROR_BIT = 32;
   localparam int RSP_TYPE_BIT  = 33;

   // Response type codes
   localparam logic RSP_READ = 1'b0;
   localparam logic RSP_WACK = 1'b1;

   // Constant request fields
   localparam logic               SRCPRIV_DEF = 1'b1;
   localparam logic [WRBE_W-1:0]  WRBE_DEF    = 4'hF;
   localparam logic [LEVEL_W-1:0] LEVEL_DEF   = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } csb_state_e;

   function automatic logic [REQ_PD_W-1:0] pack_req(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] wdat,
      input logic              write,
      input logic              nposted
   );
      logic [REQ_PD_W-1:0] pd;
      pd                              = '0;
      pd[PD_ADDR_LSB +: ADDR_W]       = addr;
      pd[PD_WDAT_LSB +: DATA_W]       = wdat;
      pd[PD_WRITE_BIT]                = write;
      pd[PD_NPOSTED_BIT]              = nposted;
      pd[PD_SRCPRIV_BIT]              = SRCPRIV_DEF;
      pd[PD_WRBE_LSB +: WRBE_W]       = WRBE_DEF;
      pd[PD_LEVEL_LSB +: LEVEL_W]     = LEVEL_DEF;
      return pd;
   endfunction

endpackage

// File: rtl/nv_nvdla_csb_init_tmo.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_init_tmo
// Response-timeout counter for the CSB initiator. Cleared when the initiator
// enters WAIT, advances once per WAIT cycle, and flags expiry on the
// TIMEOUT_CYCLES-th WAIT cycle.
// Ports:
//   i_clk      in  1  clock
//   i_rst      in  1  asynchronous active-high reset
//   i_clear    in  1  restart count (WAIT entry)
//   i_count    in  1  initiator is in WAIT this cycle
//   o_expired  out 1  this WAIT cycle is the last one before timeout
// -----------------------------------------------------------------------------
module nv_nvdla_csb_init_tmo #(
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   // The first WAIT cycle sees a count of 0, so the N-th sees N-1.
   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_count) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_count && (r_cnt == LAST);

endmodule

// File: rtl/nv_nvdla_csb_initiator.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_initiator
// CSB master for the GLB register slave. Accepts one host register command at a
// time, issues it as a csb2glb request packet and returns the GLB read data or
// write ack to the host. Posted writes complete as soon as the request is
// accepted; reads and non-posted writes wait for the GLB response.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; a valid source keeps valid and payload stable until then.
// glb2csb responses have no ready and are consumed in the cycle they appear.
//
// Build option: NVDLA_CSB_INIT_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYCLES
// cycles; without it WAIT lasts until a response and host_rsp_timeout is 0.
//
// Ports:
//   nvdla_core_clk      in   1   clock
//   nvdla_core_rst      in   1   asynchronous active-high reset
//   host_cmd_*          in/out   command (valid/ready, addr, wdat, write, nposted)
//   host_rsp_*          in/out   result (valid/ready, rdat, error, timeout)
//   csb2glb_req_*       out/in   request packet (pvld/prdy, 63-bit pd)
//   glb2csb_resp_*      in       response packet (valid, 34-bit pd)
//   stray_resp_err      out  1   sticky: response with nothing outstanding
//   busy                out  1   FSM not idle
//   dbg_state           out  2   FSM state (csb_state_e encoding)
// -----------------------------------------------------------------------------
module nv_nvdla_csb_initiator
   import nv_nvdla_csb_pkg::*;
#(
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rst,
   input  logic                  host_cmd_valid,
   output logic                  host_cmd_ready,
   input  logic [ADDR_W-1:0]     host_cmd_addr,
   input  logic [DATA_W-1:0]     host_cmd_wdat,
   input  logic                  host_cmd_write,
   input  logic                  host_cmd_nposted,
   output logic                  host_rsp_valid,
   input  logic                  host_rsp_ready,
   output logic [DATA_W-1:0]     host_rsp_rdat,
   output logic                  host_rsp_error,
   output logic                  host_rsp_timeout,
   output logic                  csb2glb_req_pvld,
   input  logic                  csb2glb_req_prdy,
   output logic [REQ_PD_W-1:0]   csb2glb_req_pd,
   input  logic                  glb2csb_resp_valid,
   input  logic [RESP_PD_W-1:0]  glb2csb_resp_pd,
   output logic                  stray_resp_err,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1 .. 2**TIMEOUT_W-1");
   end

   csb_state_e            r_state;
   csb_state_e            w_next_state;
   logic [REQ_PD_W-1:0]   r_pd;
   logic [DATA_W-1:0]     r_rdat;
   logic                  r_error;
   logic                  r_stray;

   logic                  w_cmd_accept;
   logic                  w_nonposted;
   logic                  w_resp_take;
   logic                  w_load_rsp;
   logic [DATA_W-1:0]     w_rsp_rdat;
   logic                  w_rsp_error;
   logic [DATA_W-1:0]     w_cap_rdat;
   logic                  w_cap_error;
   logic                  w_exp_type;

`ifdef NVDLA_CSB_INIT_TIMEOUT_EN
   logic                  w_tmo_clear;
   logic                  w_tmo_expired;
   logic                  w_rsp_timeout;
   logic                  r_timeout;
`endif

   assign w_cmd_accept = (r_state == ST_IDLE) && host_cmd_valid;
   // Reads always need a response; writes only when flagged non-posted.
   assign w_nonposted  = !r_pd[PD_WRITE_BIT] || r_pd[PD_NPOSTED_BIT];

   // Captured response: write acks carry no data back to the host, and a
   // response of the wrong type for the outstanding command is an error.
   assign w_exp_type  = r_pd[PD_WRITE_BIT] ? RSP_WACK : RSP_READ;
   assign w_cap_rdat  = r_pd[PD_WRITE_BIT] ? '0 : glb2csb_resp_pd[RSP_RDAT_LSB +: DATA_W];
   assign w_cap_error = glb2csb_resp_pd[RSP_ERROR_BIT] ||
                        (glb2csb_resp_pd[RSP_TYPE_BIT] != w_exp_type);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_load_rsp   = 1'b0;
      w_rsp_rdat   = '0;
      w_rsp_error  = 1'b0;
      w_resp_take  = 1'b0;
`ifdef NVDLA_CSB_INIT_TIMEOUT_EN
      w_rsp_timeout = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (host_cmd_valid) begin
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (csb2glb_req_prdy) begin
               if (!w_nonposted) begin
                  w_next_state = ST_RSP;
                  w_load_rsp   = 1'b1;
               end else if (glb2csb_resp_valid) begin
                  // Response in the handshake cycle belongs to this request.
                  w_next_state = ST_RSP;
                  w_load_rsp   = 1'b1;
                  w_resp_take  = 1'b1;
                  w_rsp_rdat   = w_cap_rdat;
                  w_rsp_error  = w_cap_error;
               end else begin
                  w_next_state = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (glb2csb_resp_valid) begin
               // Checked before expiry so a response on the last cycle wins.
               w_next_state = ST_RSP;
               w_load_rsp   = 1'b1;
               w_resp_take  = 1'b1;
               w_rsp_rdat   = w_cap_rdat;
               w_rsp_error  = w_cap_error;
            end
`ifdef NVDLA_CSB_INIT_TIMEOUT_EN
            else if (w_tmo_expired) begin
               w_next_state  = ST_RSP;
               w_load_rsp    = 1'b1;
               w_rsp_error   = 1'b1;
               w_rsp_timeout = 1'b1;
            end
`endif
         end
         ST_RSP: begin
            if (host_rsp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_pd    <= '0;
         r_rdat  <= '0;
         r_error <= 1'b0;
         r_stray <= 1'b0;
      end else begin
         if (w_cmd_accept) begin
            r_pd <= pack_req(host_cmd_addr, host_cmd_wdat, host_cmd_write, host_cmd_nposted);
         end
         if (w_load_rsp) begin
            r_rdat  <= w_rsp_rdat;
            r_error <= w_rsp_error;
         end
         // Any response not consumed by an outstanding request is dropped.
         if (glb2csb_resp_valid && !w_resp_take) begin
            r_stray <= 1'b1;
         end
      end
   end

`ifdef NVDLA_CSB_INIT_TIMEOUT_EN
   assign w_tmo_clear = (r_state == ST_REQ) && csb2glb_req_prdy && w_nonposted &&
                        !glb2csb_resp_valid;

   nv_nvdla_csb_init_tmo #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .i_clk     (nvdla_core_clk),
      .i_rst     (nvdla_core_rst),
      .i_clear   (w_tmo_clear),
      .i_count   (r_state == ST_WAIT),
      .o_expired (w_tmo_expired)
   );

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_timeout <= 1'b0;
      end else if (w_load_rsp) begin
         r_timeout <= w_rsp_timeout;
      end
   end

   assign host_rsp_timeout = r_timeout;
`else
   assign host_rsp_timeout = 1'b0;
`endif

   assign host_cmd_ready   = (r_state == ST_IDLE);
   assign csb2glb_req_pvld = (r_state == ST_REQ);
   assign csb2glb_req_pd   = r_pd;
   assign host_rsp_valid   = (r_state == ST_RSP);
   assign host_rsp_rdat    = r_rdat;
   assign host_rsp_error   = r_error;
   assign stray_resp_err   = r_stray;
   assign busy             = (r_state != ST_IDLE);
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_nv_nvdla_csb_initiator.sv
module tb_nv_nvdla_csb_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        host_cmd_valid = 1'b0;
   logic        host_cmd_ready;
   logic [21:0] host_cmd_addr = '0;
   logic [31:0] host_cmd_wdat = '0;
   logic        host_cmd_write = 1'b0;
   logic        host_cmd_nposted = 1'b0;
   logic        host_rsp_valid;
   logic        host_rsp_ready = 1'b0;
   logic [31:0] host_rsp_rdat;
   logic        host_rsp_error;
   logic        host_rsp_timeout;
   logic        csb2glb_req_pvld;
   logic        csb2glb_req_prdy = 1'b0;
   logic [62:0] csb2glb_req_pd;
   logic        glb2csb_resp_valid = 1'b0;
   logic [33:0] glb2csb_resp_pd = '0;
   logic        stray_resp_err;
   logic        busy;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   nv_nvdla_csb_initiator #(
      .TIMEOUT_W      (16),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .nvdla_core_clk     (clk),
      .nvdla_core_rst     (rst),
      .host_cmd_valid     (host_cmd_valid),
      .host_cmd_ready     (host_cmd_ready),
      .host_cmd_addr      (host_cmd_addr),
      .host_cmd_wdat      (host_cmd_wdat),
      .host_cmd_write     (host_cmd_write),
      .host_cmd_nposted   (host_cmd_nposted),
      .host_rsp_valid     (host_rsp_valid),
      .host_rsp_ready     (host_rsp_ready),
      .host_rsp_rdat      (host_rsp_rdat),
      .host_rsp_error     (host_rsp_error),
      .host_rsp_timeout   (host_rsp_timeout),
      .csb2glb_req_pvld   (csb2glb_req_pvld),
      .csb2glb_req_prdy   (csb2glb_req_prdy),
      .csb2glb_req_pd     (csb2glb_req_pd),
      .glb2csb_resp_valid (glb2csb_resp_valid),
      .glb2csb_resp_pd    (glb2csb_resp_pd),
      .stray_resp_err     (stray_resp_err),
      .busy               (busy),
      .dbg_state          (dbg_state)
   );

   // Model state: expected host results {timeout, error, rdat}, expected
   // request visibility/packet and expected sticky stray flag.
   logic [33:0] exp_q[$];
   logic        exp_pvld  = 1'b0;
   logic [62:0] exp_pd    = '0;
   logic        exp_stray = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Result the host must see, from the command kind and the GLB response.
   function automatic logic [33:0] model_rsp(input logic wr, input logic np,
                                             input logic [31:0] rd, input logic e,
                                             input logic typ);
      if (wr && !np) return {1'b0, 1'b0, 32'h0};
      if (wr)        return {1'b0, e | (typ != 1'b1), 32'h0};
      return {1'b0, e | (typ != 1'b0), rd};
   endfunction

   // Compare process
   always @(negedge clk) begin
      if (!rst) begin
         check("req_pvld", csb2glb_req_pvld, exp_pvld);
         if (exp_pvld) check("req_pd", csb2glb_req_pd, exp_pd);
         check("stray", stray_resp_err, exp_stray);
         if (host_rsp_valid) begin
            check("cmd_ready_in_rsp", host_cmd_ready, 1'b0);
            if (exp_q.size() == 0) begin
               note_fail("rsp_unexpected");
            end else begin
               check("rsp_fields", {host_rsp_timeout, host_rsp_error, host_rsp_rdat}, exp_q[0]);
               if (host_rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Driver tasks (called just after a rising edge)
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_pvld = 1'b0;
      exp_stray = 1'b0;
      exp_q.delete();
      host_cmd_valid = 1'b0;
      host_rsp_ready = 1'b0;
      csb2glb_req_prdy = 1'b0;
      glb2csb_resp_valid = 1'b0;
      #1;
      check("rst_pvld", csb2glb_req_pvld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", host_cmd_ready, 1'b1);
      check("rst_rsp_valid", host_rsp_valid, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send_cmd(input logic [21:0] a, input logic [31:0] d,
                           input logic wr, input logic np);
      int n = 0;
      while (!host_cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!host_cmd_ready) note_fail("cmd_ready_wait");
      host_cmd_valid   = 1'b1;
      host_cmd_addr    = a;
      host_cmd_wdat    = d;
      host_cmd_write   = wr;
      host_cmd_nposted = np;
      tick();
      host_cmd_valid = 1'b0;
      exp_pd   = {2'b00, 4'hF, 1'b1, np, wr, d, a};
      exp_pvld = 1'b1;
   endtask

   task automatic req_hs(input int stall, input logic with_resp, input logic [33:0] rpd);
      repeat (stall) tick();
      csb2glb_req_prdy = 1'b1;
      if (with_resp) begin
         glb2csb_resp_valid = 1'b1;
         glb2csb_resp_pd    = rpd;
      end
      tick();
      csb2glb_req_prdy   = 1'b0;
      glb2csb_resp_valid = 1'b0;
      exp_pvld           = 1'b0;
   endtask

   task automatic send_resp(input int delay, input logic [33:0] rpd);
      repeat (delay) tick();
      glb2csb_resp_valid = 1'b1;
      glb2csb_resp_pd    = rpd;
      tick();
      glb2csb_resp_valid = 1'b0;
   endtask

   task automatic send_stray(input logic [33:0] rpd);
      send_resp(0, rpd);
      exp_stray = 1'b1;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!host_rsp_valid && n < 100) begin
         tick();
         n++;
      end
      if (!host_rsp_valid) note_fail("rsp_valid_wait");
   endtask

   task automatic take_rsp(input int hold);
      repeat (hold) tick();
      host_rsp_ready = 1'b1;
      tick();
      host_rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset();
      check("rst_pd_zero", csb2glb_req_pd, 63'h0);
      check("rst_stray", stray_resp_err, 1'b0);

      // 1: read, response 3 cycles after handshake
      send_cmd(22'h0004, 32'h0, 1'b0, 1'b0);
      check("lit_read_pd", csb2glb_req_pd, 63'h1F00_0000_0000_0004);
      check("busy_after_accept", busy, 1'b1);
      exp_q.push_back(model_rsp(1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0));
      req_hs(0, 1'b0, '0);
      send_resp(2, {1'b0, 1'b0, 32'h1234_5678});
      wait_rsp();
      check("lit_read_rdat", host_rsp_rdat, 32'h1234_5678);
      check("lit_read_err", host_rsp_error, 1'b0);
      take_rsp(0);

      // 2: posted write, prdy low for 5 cycles, no GLB response expected
      send_cmd(22'h0010, 32'hA5A5_A5A5, 1'b1, 1'b0);
      check("lit_pwr_pd", csb2glb_req_pd, 63'h1F69_6969_6940_0010);
      exp_q.push_back(model_rsp(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      req_hs(5, 1'b0, '0);
      check("lit_pwr_rsp_now", host_rsp_valid, 1'b1);
      take_rsp(1);

      // 3: non-posted writes: type mismatch, slave error, clean ack
      send_cmd(22'h3F_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b1);
      exp_q.push_back(model_rsp(1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
      req_hs(1, 1'b0, '0);
      send_resp(1, {1'b0, 1'b0, 32'h5555_0000});
      wait_rsp();
      check("lit_npw_mismatch_err", host_rsp_error, 1'b1);
      take_rsp(0);

      send_cmd(22'h0020, 32'h0000_0001, 1'b1, 1'b1);
      exp_q.push_back(model_rsp(1'b1, 1'b1, 32'h0, 1'b1, 1'b1));
      req_hs(0, 1'b0, '0);
      send_resp(0, {1'b1, 1'b1, 32'h0});
      wait_rsp();
      check("lit_npw_slave_err", host_rsp_error, 1'b1);
      take_rsp(0);

      send_cmd(22'h0024, 32'h8000_0000, 1'b1, 1'b1);
      exp_q.push_back(model_rsp(1'b1, 1'b1, 32'h0, 1'b0, 1'b1));
      req_hs(0, 1'b0, '0);
      send_resp(4, {1'b1, 1'b0, 32'hFFFF_FFFF});
      wait_rsp();
      take_rsp(2);

      // read with response in the handshake cycle
      send_cmd(22'h0100, 32'h0, 1'b0, 1'b1);
      exp_q.push_back(model_rsp(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0));
      req_hs(2, 1'b1, {1'b0, 1'b0, 32'h0BAD_F00D});
      check("lit_samecyc_rsp", host_rsp_valid, 1'b1);
      take_rsp(0);

      // read whose response lands on the last allowed WAIT cycle
      send_cmd(22'h0200, 32'h0, 1'b0, 1'b0);
      exp_q.push_back(model_rsp(1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0));
      req_hs(0, 1'b0, '0);
      send_resp(TMO - 1, {1'b0, 1'b0, 32'hCAFE_F00D});
      wait_rsp();
      check("lit_lastcyc_tmo", host_rsp_timeout, 1'b0);
      take_rsp(0);

      // 4: stray response while idle, persists through a clean read
      send_stray({1'b0, 1'b0, 32'h1111_1111});
      check("lit_stray_set", stray_resp_err, 1'b1);
      send_cmd(22'h0008, 32'h0, 1'b0, 1'b0);
      exp_q.push_back(model_rsp(1'b0, 1'b0, 32'h0000_00A5, 1'b0, 1'b0));
      req_hs(0, 1'b0, '0);
      send_resp(1, {1'b0, 1'b0, 32'h0000_00A5});
      wait_rsp();
      take_rsp(0);
      check("lit_stray_kept", stray_resp_err, 1'b1);
      do_reset();
      check("lit_stray_cleared", stray_resp_err, 1'b0);

`ifdef NVDLA_CSB_INIT_TIMEOUT_EN
      // 5: timeout after TMO WAIT cycles, then late response is stray
      begin
         int n = 0;
         send_cmd(22'h0300, 32'h0, 1'b0, 1'b0);
         exp_q.push_back({1'b1, 1'b1, 32'h0});
         req_hs(0, 1'b0, '0);
         while (!host_rsp_valid && n < 50) begin
            tick();
            n++;
         end
         check("tmo_wait_cycles", n, TMO);
         check("lit_tmo_flags", {host_rsp_timeout, host_rsp_error}, 2'b11);
         take_rsp(0);
         send_stray({1'b0, 1'b0, 32'h2222_2222});
         check("lit_tmo_late_stray", stray_resp_err, 1'b1);
         do_reset();
      end
`endif

      // 6: reset while in WAIT, then late response
      send_cmd(22'h0400, 32'h0, 1'b0, 1'b0);
      req_hs(0, 1'b0, '0);
      tick();
      check("wait_busy", busy, 1'b1);
      do_reset();
      send_stray({1'b0, 1'b0, 32'h3333_3333});
      check("lit_late_after_rst", stray_resp_err, 1'b1);
      do_reset();

      // reset while the request is presented
      send_cmd(22'h0500, 32'h7777_7777, 1'b1, 1'b0);
      tick();
      check("req_pvld_before_rst", csb2glb_req_pvld, 1'b1);
      do_reset();

      // held result: fields stable while host_rsp_ready stays low
      send_cmd(22'h0600, 32'h0, 1'b0, 1'b0);
      exp_q.push_back(model_rsp(1'b0, 1'b0, 32'h0F0F_0F0F, 1'b1, 1'b0));
      req_hs(0, 1'b0, '0);
      send_resp(0, {1'b0, 1'b1, 32'h0F0F_0F0F});
      wait_rsp();
      take_rsp(4);
      tick();
      check("end_idle", busy, 1'b0);
      check("end_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
